// File: rtl/tt_um_diego_top.sv
// tt_um_diego_top
// Tiny Tapeout user block: an 8-bit command-driven accumulator with status
// flags, plus a free-running PWM generator whose duty cycle comes from a
// compare register.
//
// Pin usage:
//   ui_in      data operand D
//   uio_in     [2:0] command, [7:3] ignored
//   uo_out     accumulator
//   uio_out    [4] ZERO, [5] CARRY, [6] PWM, [7] MATCH, [3:0] tied low
//   uio_oe     upper nibble driven, lower nibble left as inputs
//
// The reset pin keeps the board-level name rst_n, but it is active-high:
// a 1 clears every register immediately, without waiting for a clock edge.
// Every output is derived from registered state only, so ui_in and uio_in
// have no combinational path to the pins.

module tt_um_diego_top (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        CMD_NOP    = 3'b000,
        CMD_LOAD   = 3'b001,
        CMD_INC    = 3'b010,
        CMD_DEC    = 3'b011,
        CMD_SETCMP = 3'b100,
        CMD_CLR    = 3'b101,
        CMD_ADD    = 3'b110,
        CMD_SUB    = 3'b111
    } cmd_t;

    cmd_t       cmd;
    logic [7:0] acc;
    logic [7:0] cmp;
    logic       carry;
    logic [7:0] pwm_count;

    logic [7:0] acc_next;
    logic [7:0] cmp_next;
    logic       carry_next;

    logic [8:0] add_result;
    logic [8:0] sub_result;

    logic       zero_flag;
    logic       match_flag;
    logic       pwm_out;

    logic       unused_uio_bits;

    assign cmd             = cmd_t'(uio_in[2:0]);
    assign unused_uio_bits = &uio_in[7:3];

    // Both wide results are formed with a spare top bit: for ADD it is the
    // carry out, for SUB it is the borrow (set exactly when D > ACC).
    assign add_result = {1'b0, acc} + {1'b0, ui_in};
    assign sub_result = {1'b0, acc} - {1'b0, ui_in};

    // Decode the command into the next accumulator, carry and compare values
    always_comb begin
        acc_next   = acc;
        cmp_next   = cmp;
        carry_next = carry;
        case (cmd)
            CMD_NOP: begin
                acc_next   = acc;
                carry_next = carry;
            end
            CMD_LOAD: begin
                acc_next   = ui_in;
                carry_next = 1'b0;
            end
            CMD_INC: begin
                acc_next   = acc + 8'd1;
                carry_next = (acc == 8'hFF);
            end
            CMD_DEC: begin
                acc_next   = acc - 8'd1;
                carry_next = (acc == 8'h00);
            end
            CMD_SETCMP: begin
                cmp_next = ui_in;
            end
            CMD_CLR: begin
                acc_next   = 8'h00;
                carry_next = 1'b0;
            end
            CMD_ADD: begin
                acc_next   = add_result[7:0];
                carry_next = add_result[8];
            end
            CMD_SUB: begin
                acc_next   = sub_result[7:0];
                carry_next = sub_result[8];
            end
            default: begin
                acc_next   = acc;
                carry_next = carry;
            end
        endcase
    end

    // Architectural registers; everything, including the PWM counter, freezes while ena is low
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc       <= 8'h00;
            cmp       <= 8'h00;
            carry     <= 1'b0;
            pwm_count <= 8'h00;
        end else if (ena) begin
            acc       <= acc_next;
            cmp       <= cmp_next;
            carry     <= carry_next;
            pwm_count <= pwm_count + 8'd1;
        end
    end

    // Status and PWM come straight from registered state. Because the
    // comparison is a strict less-than, CMP=0 never drives PWM high and
    // CMP=255 holds it high for 255 of the 256 counter values.
    always_comb begin
        zero_flag  = (acc == 8'h00);
        match_flag = (acc == cmp);
        pwm_out    = (pwm_count < cmp);
    end

    assign uo_out  = acc;
    assign uio_out = {match_flag, pwm_out, carry, zero_flag, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_diego_top.sv
// Testbench for tt_um_diego_top: directed sequences plus randomized
// commands, checked against an arithmetic reference model of the
// accumulator, compare register and PWM counter.

module tb_tt_um_diego_top;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int assertCount;
    int failCount;

    int modelAcc;
    int modelCmp;
    int modelCarry;
    int modelP;

    tt_um_diego_top dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        modelAcc   = 0;
        modelCmp   = 0;
        modelCarry = 0;
        modelP     = 0;
    endtask

    task automatic modelStep(input int cmd, input int d);
        int sum;
        case (cmd)
            1: begin modelAcc = d; modelCarry = 0; end
            2: begin modelCarry = (modelAcc == 255) ? 1 : 0; modelAcc = (modelAcc + 1) % 256; end
            3: begin modelCarry = (modelAcc == 0) ? 1 : 0; modelAcc = (modelAcc + 255) % 256; end
            4: modelCmp = d;
            5: begin modelAcc = 0; modelCarry = 0; end
            6: begin sum = modelAcc + d; modelCarry = (sum > 255) ? 1 : 0; modelAcc = sum % 256; end
            7: begin modelCarry = (d > modelAcc) ? 1 : 0; modelAcc = (modelAcc - d + 256) % 256; end
            default: ;
        endcase
        modelP = (modelP + 1) % 256;
    endtask

    function automatic logic [7:0] expectedUio();
        logic [7:0] v;
        v    = 8'h00;
        v[4] = (modelAcc == 0);
        v[5] = (modelCarry != 0);
        v[6] = (modelP < modelCmp);
        v[7] = (modelAcc == modelCmp);
        return v;
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, ".acc"}, {24'd0, uo_out}, modelAcc);
        checkOutput({tag, ".uio"}, {24'd0, uio_out}, {24'd0, expectedUio()});
        checkOutput({tag, ".oe"}, {24'd0, uio_oe}, 32'h0000_00F0);
    endtask

    // Drive one cycle of stimulus just after an edge, let the next edge take it,
    // advance the model, then check #1 later.
    task automatic applyStimulus(input logic en, input logic [2:0] cmd, input logic [7:0] d, input string tag);
        logic [4:0] junk;
        junk   = 5'($urandom_range(0, 31));
        ena    = en;
        ui_in  = d;
        uio_in = {junk, cmd};
        @(posedge clk);
        if (en) modelStep(int'(cmd), int'(d));
        #1;
        checkAll(tag);
    endtask

    task automatic countPwm(input logic [7:0] cmpVal, input int expectedHigh, input string tag);
        int highs;
        applyStimulus(1'b1, 3'b100, cmpVal, {tag, ".set"});
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 3'b000, 8'($urandom_range(0, 255)), {tag, ".nop"});
            if (uio_out[6]) highs++;
        end
        checkOutput({tag, ".highs"}, highs, expectedHigh);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n       = 1'b1;
        ena         = 1'b1;
        ui_in       = 8'h00;
        uio_in      = 8'h00;
        modelReset();

        // Reset held with the clock running
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.acc", {24'd0, uo_out}, 32'h00);
        checkOutput("reset.uio", {24'd0, uio_out}, 32'h90);
        checkOutput("reset.oe", {24'd0, uio_oe}, 32'hF0);
        #1;
        rst_n = 1'b0;

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 3'b000, 8'hA5, "nop_after_reset");
        checkOutput("nop5.uio", {24'd0, uio_out}, 32'h90);

        // Load / arithmetic
        applyStimulus(1'b1, 3'b001, 8'hF0, "load_f0");
        applyStimulus(1'b1, 3'b110, 8'h20, "add_20");
        checkOutput("add.acc", {24'd0, uo_out}, 32'h10);
        checkOutput("add.carry", {31'd0, uio_out[5]}, 32'd1);
        applyStimulus(1'b1, 3'b111, 8'h11, "sub_11");
        checkOutput("sub.acc", {24'd0, uo_out}, 32'hFF);
        checkOutput("sub.borrow", {31'd0, uio_out[5]}, 32'd1);
        checkOutput("sub.zero", {31'd0, uio_out[4]}, 32'd0);

        // Wrap-around
        applyStimulus(1'b1, 3'b001, 8'hFF, "load_ff");
        applyStimulus(1'b1, 3'b010, 8'h00, "inc_wrap");
        checkOutput("incwrap.acc", {24'd0, uo_out}, 32'h00);
        checkOutput("incwrap.carry", {31'd0, uio_out[5]}, 32'd1);
        checkOutput("incwrap.zero", {31'd0, uio_out[4]}, 32'd1);
        applyStimulus(1'b1, 3'b011, 8'h00, "dec_wrap");
        checkOutput("decwrap.acc", {24'd0, uo_out}, 32'hFF);
        checkOutput("decwrap.carry", {31'd0, uio_out[5]}, 32'd1);
        applyStimulus(1'b1, 3'b001, 8'h05, "load_05");
        applyStimulus(1'b1, 3'b010, 8'h00, "inc_05");
        checkOutput("inc05.carry", {31'd0, uio_out[5]}, 32'd0);

        // Compare / match
        applyStimulus(1'b1, 3'b100, 8'h2A, "setcmp_2a");
        applyStimulus(1'b1, 3'b001, 8'h2A, "load_2a");
        checkOutput("match.hi", {31'd0, uio_out[7]}, 32'd1);
        applyStimulus(1'b1, 3'b010, 8'h00, "inc_2a");
        checkOutput("match.lo", {31'd0, uio_out[7]}, 32'd0);
        checkOutput("match.acc", {24'd0, uo_out}, 32'h2B);

        // PWM duty over a full period
        countPwm(8'h40, 64, "pwm40");
        countPwm(8'h00, 0, "pwm00");
        countPwm(8'hFF, 255, "pwmff");

        // Enable low freezes everything
        applyStimulus(1'b1, 3'b001, 8'h12, "load_12");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'b001, 8'h55, "ena_low");
        checkOutput("ena.acc", {24'd0, uo_out}, 32'h12);

        // Asynchronous reset between edges during an ADD sequence
        applyStimulus(1'b1, 3'b110, 8'h33, "add_seq0");
        applyStimulus(1'b1, 3'b110, 8'h44, "add_seq1");
        #2;
        rst_n = 1'b1;
        #1;
        modelReset();
        checkOutput("abort.acc", {24'd0, uo_out}, 32'h00);
        checkOutput("abort.uio", {24'd0, uio_out}, 32'h90);
        #1;
        rst_n = 1'b0;

        // Randomized commands, data and enable
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
                          8'($urandom_range(0, 255)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
